tt_bist_harness: RTL and testbench
==================================

Name: tt_bist_harness

Overview:
- Synthesizable built-in self-test harness that wraps one TinyTapeout user design through the standard tt_um port set.
- Generates stimulus on ui_in/uio_in, controls the DUT's rst_n and ena, and samples uo_out/uio_out/uio_oe after a settle window.
- Compresses every sample into a MISR signature and reports pass/fail against an expected value.
- Parametrised successor to the fixed 8/8/8 bench wiring: widths, vector count, settle time and stimulus mode are all configurable.

Parameters:
- UI_W, 8, dedicated input width (ui_in / uo_out)
- UIO_W, 8, bidirectional width (uio_in / uio_out / uio_oe)
- NUM_VECTORS, 256, vectors per run (>=1)
- SETTLE, 2, extra cycles each vector is held before sampling (>=0)
- RST_CYCLES, 4, cycles the DUT is held in reset at run start (>=1)
- MISR_W, 32, signature width (>= 2*UIO_W+UI_W)
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial
- LFSR_POLY, 16'hB400, Galois LFSR taps for stimulus (width UI_W+UIO_W)
- LFSR_SEED, 16'hACE1, LFSR reset/start value (nonzero)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; starts a run when idle or done
- abort  in  1  stops a run immediately
- mode  in  2  stimulus mode: 0 counter, 1 LFSR, 2 walking-one, 3 constant
- const_pat  in  UI_W+UIO_W  pattern for mode 3
- expected_sig  in  MISR_W  golden signature
- dut_ui_in  out  UI_W  stimulus to DUT ui_in
- dut_uio_in  out  UIO_W  stimulus to DUT uio_in
- dut_rst_n  out  1  DUT reset, active low
- dut_ena  out  1  DUT enable
- dut_uo_out  in  UI_W  DUT output
- dut_uio_out  in  UIO_W  DUT bidir output
- dut_uio_oe  in  UIO_W  DUT bidir enable
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start or rst
- pass  out  1  valid while done: signature == expected_sig
- signature  out  MISR_W  current MISR value
- vec_idx  out  clog2(NUM_VECTORS+1)  index of the vector being applied

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst). All outputs are registered.
- Reset values: state IDLE; stim=0; dut_rst_n=0; dut_ena=0; busy=0; done=0; pass=0; signature=0; vec_idx=0.
- Stimulus word S has width UI_W+UIO_W: dut_ui_in=S[UI_W-1:0], dut_uio_in=S[top:UI_W].
- Sample word C = {dut_uio_oe, dut_uio_out & dut_uio_oe, dut_uo_out}, zero-extended to MISR_W. Undriven uio bits are masked to 0.
- MISR update: sig <= ({sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0)) ^ C.
- States:
  - IDLE: busy=0.
  - start=1 -> RESET_DUT. On this transition: signature=0, vec_idx=0, done=0, pass=0, dut_ena=1, dut_rst_n=0, S=0, mode latched internally.
  - RESET_DUT: lasts RST_CYCLES cycles. On exit: dut_rst_n=1, S = first vector -> APPLY.
  - First vector by mode: 0 -> 0; 1 -> LFSR_SEED; 2 -> 1; 3 -> const_pat.
  - APPLY: S held for SETTLE+1 cycles. On the last of these edges the MISR absorbs C.
  - After the sample, if vec_idx==NUM_VECTORS-1 -> DONE. Otherwise vec_idx+1 and S advances on the same edge.
  - Advance by mode: 0 -> S+1, wrapping modulo 2^(UI_W+UIO_W); 1 -> Galois LFSR step; 2 -> rotate left by 1 (walking one wraps); 3 -> const_pat re-sampled.
  - DONE: busy=0, done=1, pass=(signature==expected_sig). DUT left enabled with the last stimulus. start -> new run.
- Latency: run length from the start edge to done=1 is RST_CYCLES + NUM_VECTORS*(SETTLE+1) cycles.
- busy=1 exactly in RESET_DUT and APPLY.
- start while busy is ignored.
- abort (any state) -> IDLE next edge: dut_rst_n=0, dut_ena=0, S=0, busy=0, done=0, pass=0. signature keeps its partial value.
- abort and start in the same cycle: abort wins.
- rst mid-run: all registers take reset values immediately; the DUT sees dut_rst_n=0 asynchronously.
- mode and const_pat changes during a run: mode is ignored (latched at start); const_pat is re-sampled every vector in mode 3.

Test Plan:
- Counter run: mode=0, NUM_VECTORS=4, SETTLE=2, loopback DUT (uo_out=ui_in, oe=0).
  - Stimulus must be 0,1,2,3, each held 3 cycles.
  - done must rise 4+12=16 cycles after start.
  - signature must equal the reference-model MISR.
  - pass=1 when expected_sig is set to that value, pass=0 when it is flipped by 1 bit.
- Walking-one wrap: mode=2, NUM_VECTORS=18 -> S goes 0x0001..0x8000, then 0x0001, 0x0002.
- LFSR: mode=1 -> first S=0xACE1; following values match the software Galois model for 0xB400; S is never 0.
- uio masking: DUT drives uio_out=0xFF with uio_oe=0x0F -> C middle byte must be 0x0F; changing the undriven bits must leave signature unchanged.
- Abort mid-run at vector 5 -> next cycle busy=0, dut_rst_n=0, dut_ena=0, done=0. A following start restarts from vec_idx=0 with signature=0.
- Asynchronous rst asserted between clock edges during APPLY -> dut_rst_n, busy and signature go to 0 without waiting for a clk edge. start while busy -> no effect on vec_idx.

Source files
------------

// File: rtl/tt_bist_harness_if.sv
// TinyTapeout tt_um-style connection between the BIST harness (master) and
// the wrapped user design (slave).
interface tt_bist_harness_if #(
  parameter int UI_W  = 8,
  parameter int UIO_W = 8
);
  logic [UI_W-1:0]  dut_ui_in;
  logic [UIO_W-1:0] dut_uio_in;
  logic             dut_rst_n;
  logic             dut_ena;
  logic [UI_W-1:0]  dut_uo_out;
  logic [UIO_W-1:0] dut_uio_out;
  logic [UIO_W-1:0] dut_uio_oe;

  modport master (
    output dut_ui_in, dut_uio_in, dut_rst_n, dut_ena,
    input  dut_uo_out, dut_uio_out, dut_uio_oe
  );

  modport slave (
    input  dut_ui_in, dut_uio_in, dut_rst_n, dut_ena,
    output dut_uo_out, dut_uio_out, dut_uio_oe
  );
endinterface

// File: rtl/tt_bist_harness.sv
// Built-in self-test harness for one tt_um design: drives stimulus, holds it
// for a settle window, and folds every DUT response into a MISR signature.
module tt_bist_harness #(
  parameter int                      UI_W        = 8,
  parameter int                      UIO_W       = 8,
  parameter int                      NUM_VECTORS = 256,
  parameter int                      SETTLE      = 2,
  parameter int                      RST_CYCLES  = 4,
  parameter int                      MISR_W      = 32,
  parameter logic [MISR_W-1:0]       MISR_POLY   = 32'h04C11DB7,
  parameter logic [UI_W+UIO_W-1:0]   LFSR_POLY   = 16'hB400,
  parameter logic [UI_W+UIO_W-1:0]   LFSR_SEED   = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic [1:0]                         mode,
  input  logic [UI_W+UIO_W-1:0]              const_pat,
  input  logic [MISR_W-1:0]                  expected_sig,
  tt_bist_harness_if.master                  dut,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [MISR_W-1:0]                  signature,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_idx
);
  localparam int SW      = UI_W + UIO_W;
  localparam int CW      = 2*UIO_W + UI_W;
  localparam int CNT_MAX = (RST_CYCLES > SETTLE+1) ? RST_CYCLES : SETTLE+1;
  localparam int CNT_W   = $clog2(CNT_MAX+1);
  localparam int VI_W    = $clog2(NUM_VECTORS+1);

  typedef enum logic [1:0] {IDLE, RESET_DUT, APPLY, DONE} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        run_mode;
  logic [SW-1:0]     stim, stim_d;
  logic [MISR_W-1:0] sig_d, misr_next;
  logic [CW-1:0]     cap;
  logic              rst_n_q, ena_q;
  logic              start_run, rst_exit, sample;

  function automatic logic [SW-1:0] first_vec(input logic [1:0] m, input logic [SW-1:0] cp);
    case (m)
      2'd0:    return '0;
      2'd1:    return LFSR_SEED;
      2'd2:    return SW'(1);
      default: return cp;
    endcase
  endfunction

  function automatic logic [SW-1:0] advance(input logic [1:0] m, input logic [SW-1:0] s,
                                            input logic [SW-1:0] cp);
    case (m)
      2'd0:    return s + SW'(1);
      2'd1:    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
      2'd2:    return {s[SW-2:0], s[SW-1]};
      default: return cp;
    endcase
  endfunction

  // Undriven bidirectional bits are masked so floating pins never reach the MISR.
  assign cap       = {dut.dut_uio_oe, dut.dut_uio_out & dut.dut_uio_oe, dut.dut_uo_out};
  assign misr_next = ({signature[MISR_W-2:0], 1'b0} ^ (signature[MISR_W-1] ? MISR_POLY : '0))
                     ^ MISR_W'(cap);

  assign dut.dut_ui_in  = stim[UI_W-1:0];
  assign dut.dut_uio_in = stim[SW-1:UI_W];
  assign dut.dut_rst_n  = rst_n_q;
  assign dut.dut_ena    = ena_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    rst_exit   = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        next_state = RESET_DUT;
        start_run  = 1'b1;
      end
      RESET_DUT: if (cnt == CNT_W'(RST_CYCLES-1)) begin
        next_state = APPLY;
        rst_exit   = 1'b1;
      end
      APPLY: if (cnt == CNT_W'(SETTLE)) begin
        sample = 1'b1;
        if (vec_idx == VI_W'(NUM_VECTORS-1)) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
    // Abort overrides everything, including a coincident start or sample.
    if (abort) begin
      next_state = IDLE;
      start_run  = 1'b0;
      rst_exit   = 1'b0;
      sample     = 1'b0;
    end

    stim_d = stim;
    sig_d  = signature;
    if (abort) begin
      stim_d = '0;
    end else if (start_run) begin
      stim_d = '0;
      sig_d  = '0;
    end else if (rst_exit) begin
      stim_d = first_vec(run_mode, const_pat);
    end else if (sample) begin
      sig_d = misr_next;
      if (next_state == APPLY) stim_d = advance(run_mode, stim, const_pat);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim      <= '0;
      signature <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      rst_n_q   <= 1'b0;
      ena_q     <= 1'b0;
      run_mode  <= '0;
      cnt       <= '0;
      vec_idx   <= '0;
    end else begin
      stim      <= stim_d;
      signature <= sig_d;
      busy      <= (next_state == RESET_DUT) || (next_state == APPLY);
      done      <= (next_state == DONE);
      pass      <= (next_state == DONE) && (sig_d == expected_sig);
      if (abort) begin
        rst_n_q <= 1'b0;
        ena_q   <= 1'b0;
      end else if (start_run) begin
        rst_n_q  <= 1'b0;
        ena_q    <= 1'b1;
        run_mode <= mode;
        cnt      <= '0;
        vec_idx  <= '0;
      end else if (rst_exit) begin
        rst_n_q <= 1'b1;
        cnt     <= '0;
      end else if (state == RESET_DUT) begin
        cnt <= cnt + CNT_W'(1);
      end else if (state == APPLY) begin
        if (sample) begin
          cnt <= '0;
          if (next_state == APPLY) vec_idx <= vec_idx + VI_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: two harness instances around loopback DUT models,
// table-driven runs on a 4-vector harness plus hand sequences on an 18-vector one.
module tb_tt_bist_harness;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, abort;
  logic [1:0]  mode;
  logic [15:0] const_pat;
  logic [31:0] expected_sig;
  logic [7:0]  uio_drv, oe_drv;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [31:0] sig_a, sig_b;
  logic [2:0]  vi_a;
  logic [4:0]  vi_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  tt_bist_harness_if #(.UI_W(8), .UIO_W(8)) ifa ();
  tt_bist_harness_if #(.UI_W(8), .UIO_W(8)) ifb ();

  assign ifa.dut_uo_out  = ifa.dut_ui_in;
  assign ifa.dut_uio_out = uio_drv;
  assign ifa.dut_uio_oe  = oe_drv;
  assign ifb.dut_uo_out  = ifb.dut_ui_in;
  assign ifb.dut_uio_out = uio_drv;
  assign ifb.dut_uio_oe  = oe_drv;

  tt_bist_harness #(.UI_W(8), .UIO_W(8), .NUM_VECTORS(4), .SETTLE(2), .RST_CYCLES(4)) ua (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .mode(mode), .const_pat(const_pat),
    .expected_sig(expected_sig), .dut(ifa.master), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .vec_idx(vi_a));

  tt_bist_harness #(.UI_W(8), .UIO_W(8), .NUM_VECTORS(18), .SETTLE(0), .RST_CYCLES(4)) ub (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .mode(mode), .const_pat(const_pat),
    .expected_sig(expected_sig), .dut(ifb.master), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .vec_idx(vi_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] c);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ 32'h04C11DB7;
    return r ^ c;
  endfunction

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  typedef struct packed {
    logic [1:0]       mode;
    logic [15:0]      cpat;
    logic [7:0]       drv;
    logic [7:0]       oe;
    logic [3:0][15:0] s;
  } vec_t;

  vec_t tbl [6];

  task automatic pulse_b();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
  endtask

  // 18-vector run with SETTLE=0: vector v is on the pins after edge 4+v.
  task automatic run_b(input logic [1:0] m);
    logic [15:0] e, s;
    mode = m;
    pulse_b();
    e = 16'hACE1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k >= 4 && k <= 21) begin
        s = {ifb.dut_uio_in, ifb.dut_ui_in};
        if (m == 2'd2) begin
          if (k - 4 < 16) e = 16'h0001 << (k - 4);
          else            e = 16'h0001 << (k - 20);
        end
        chk("b_stim", 32'(s), 32'(e));
        if (m == 2'd1) begin
          chk("lfsr_nonzero", 32'(s != 16'h0), 32'd1);
          e = lfsr_ref(e);
        end
      end
      chk("b_done", 32'(done_b), 32'(k == 22));
    end
  endtask

  initial begin
    logic [31:0] exp_sig;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; mode = 2'd0;
    const_pat = 16'h0; expected_sig = 32'h0; uio_drv = 8'h0; oe_drv = 8'h0;

    tbl[0].mode = 2'd0; tbl[0].cpat = 16'h0000; tbl[0].drv = 8'h00; tbl[0].oe = 8'h00;
    tbl[0].s = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    tbl[1].mode = 2'd1; tbl[1].cpat = 16'h0000; tbl[1].drv = 8'h00; tbl[1].oe = 8'h00;
    tbl[1].s = {16'h389C, 16'h7138, 16'hE270, 16'hACE1};
    tbl[2].mode = 2'd2; tbl[2].cpat = 16'h0000; tbl[2].drv = 8'h00; tbl[2].oe = 8'h00;
    tbl[2].s = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
    tbl[3].mode = 2'd3; tbl[3].cpat = 16'h5AA5; tbl[3].drv = 8'hA5; tbl[3].oe = 8'hF0;
    tbl[3].s = {16'h5AA5, 16'h5AA5, 16'h5AA5, 16'h5AA5};
    tbl[4].mode = 2'd3; tbl[4].cpat = 16'h1234; tbl[4].drv = 8'hFF; tbl[4].oe = 8'h0F;
    tbl[4].s = {16'h1234, 16'h1234, 16'h1234, 16'h1234};
    tbl[5].mode = 2'd3; tbl[5].cpat = 16'h1234; tbl[5].drv = 8'h0F; tbl[5].oe = 8'h0F;
    tbl[5].s = {16'h1234, 16'h1234, 16'h1234, 16'h1234};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_pass",  32'(pass_a), 32'd0);
    chk("rst_sig",   sig_a, 32'd0);
    chk("rst_vidx",  32'(vi_a), 32'd0);
    chk("rst_rstn",  32'(ifa.dut_rst_n), 32'd0);
    chk("rst_ena",   32'(ifa.dut_ena), 32'd0);
    chk("rst_stim",  32'({ifa.dut_uio_in, ifa.dut_ui_in}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode; const_pat = tbl[i].cpat;
      uio_drv = tbl[i].drv; oe_drv = tbl[i].oe;
      exp_sig = 32'h0;
      for (int v = 0; v < 4; v++)
        exp_sig = misr_ref(exp_sig, {8'h00, tbl[i].oe, tbl[i].drv & tbl[i].oe, tbl[i].s[v][7:0]});
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      mode = ~tbl[i].mode;
      chk("a_start_busy", 32'(busy_a), 32'd1);
      chk("a_start_sig",  sig_a, 32'd0);
      chk("a_start_vidx", 32'(vi_a), 32'd0);
      chk("a_start_ena",  32'(ifa.dut_ena), 32'd1);
      for (int k = 1; k <= 16; k++) begin
        step();
        chk("a_rstn", 32'(ifa.dut_rst_n), 32'(k >= 4));
        if (k >= 4 && k <= 15)
          chk("a_stim", 32'({ifa.dut_uio_in, ifa.dut_ui_in}), 32'(tbl[i].s[(k-4)/3]));
        chk("a_done", 32'(done_a), 32'(k == 16));
        chk("a_busy", 32'(busy_a), 32'(k < 16));
      end
      chk("a_sig", sig_a, exp_sig);
      expected_sig = exp_sig;
      step();
      chk("a_pass_match", 32'(pass_a), 32'd1);
      expected_sig = exp_sig ^ 32'h0000_0100;
      step();
      chk("a_pass_flip", 32'(pass_a), 32'd0);
      chk("a_done_hold", 32'(done_a), 32'd1);
    end

    uio_drv = 8'h00; oe_drv = 8'h00; const_pat = 16'h0;
    run_b(2'd2);
    run_b(2'd1);

    // Abort with vector 5 on the pins; vectors 0..4 have been absorbed.
    mode = 2'd0;
    pulse_b();
    for (int k = 1; k <= 9; k++) step();
    chk("ab_vidx", 32'(vi_b), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_sig = 32'h0;
    for (int v = 0; v < 5; v++) exp_sig = misr_ref(exp_sig, 32'(v));
    chk("ab_busy", 32'(busy_b), 32'd0);
    chk("ab_rstn", 32'(ifb.dut_rst_n), 32'd0);
    chk("ab_ena",  32'(ifb.dut_ena), 32'd0);
    chk("ab_done", 32'(done_b), 32'd0);
    chk("ab_stim", 32'({ifb.dut_uio_in, ifb.dut_ui_in}), 32'd0);
    chk("ab_sig",  sig_b, exp_sig);
    abort = 1'b1; start_b = 1'b1;
    step();
    abort = 1'b0; start_b = 1'b0;
    chk("ab_start_same", 32'(busy_b), 32'd0);
    pulse_b();
    chk("re_vidx", 32'(vi_b), 32'd0);
    chk("re_sig",  sig_b, 32'd0);
    chk("re_busy", 32'(busy_b), 32'd1);

    for (int k = 1; k <= 7; k++) step();
    exp_sig = 32'h0;
    for (int v = 0; v < 3; v++) exp_sig = misr_ref(exp_sig, 32'(v));
    chk("mid_sig", sig_b, exp_sig);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("busy_start_vidx", 32'(vi_b), 32'd4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rstn", 32'(ifb.dut_rst_n), 32'd0);
    chk("arst_busy", 32'(busy_b), 32'd0);
    chk("arst_sig",  sig_b, 32'd0);
    chk("arst_vidx", 32'(vi_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
